// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system ID and build timestamp and checks the ID.
// Define SYSID_READER_TS_CHECK_EN to also require the timestamp to match EXPECTED_TS.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_live;
    logic        r_drop;
    logic [15:0] r_tcnt;
    logic [3:0]  r_retry;
    logic [31:0] r_id;
    logic [31:0] r_ts;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_tmo;

    logic w_go;
    logic w_req;
    logic w_wait;
    logic w_take;
    logic w_tmo;
    logic w_retry;
    logic w_enter_req;
    logic w_id_phase;
    logic w_ts_ok;
    logic w_pass_cond;

    // r_live holds the master off for the first clock after reset; r_drop forces
    // a one-cycle read gap between a timed-out attempt and its retry.
    assign w_go       = r_live & ~r_drop;
    assign w_req      = (r_state == S_ID_REQ) | (r_state == S_TS_REQ);
    assign w_wait     = (r_state == S_ID_WAIT) | (r_state == S_TS_WAIT);
    assign w_id_phase = (r_state == S_ID_REQ) | (r_state == S_ID_WAIT);

    // Data is taken only in a wait state or with a zero-latency accept; stale responses are dropped.
    assign w_take  = w_go & avm_readdatavalid & (w_wait | (w_req & ~avm_waitrequest));
    assign w_tmo   = w_go & (w_req | w_wait) & (r_tcnt == TMO_LAST) & ~w_take;
    assign w_retry = w_tmo & (r_retry < RETRY_MAX);

    assign w_enter_req = w_go & ((w_next == S_ID_REQ) | (w_next == S_TS_REQ))
                       & ((w_next != r_state) | w_tmo);

`ifdef SYSID_READER_TS_CHECK_EN
    assign w_ts_ok = (r_ts == EXPECTED_TS);
`else
    // Timestamp is exported only; the OR keeps EXPECTED_TS referenced without affecting the result.
    assign w_ts_ok = 1'b1 | (r_ts == EXPECTED_TS);
`endif
    assign w_pass_cond = (r_id == EXPECTED_ID) & w_ts_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_ID_REQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_go) begin
            case (r_state)
                S_IDLE:    w_next = S_ID_REQ;
                S_ID_REQ: begin
                    if (w_tmo)                 w_next = w_retry ? S_ID_REQ : S_DONE;
                    else if (!avm_waitrequest) w_next = w_take ? S_TS_REQ : S_ID_WAIT;
                end
                S_ID_WAIT: begin
                    if (w_take)     w_next = S_TS_REQ;
                    else if (w_tmo) w_next = w_retry ? S_ID_REQ : S_DONE;
                end
                S_TS_REQ: begin
                    if (w_tmo)                 w_next = w_retry ? S_ID_REQ : S_DONE;
                    else if (!avm_waitrequest) w_next = w_take ? S_CHECK : S_TS_WAIT;
                end
                S_TS_WAIT: begin
                    if (w_take)     w_next = S_CHECK;
                    else if (w_tmo) w_next = w_retry ? S_ID_REQ : S_DONE;
                end
                S_CHECK:   w_next = S_DONE;
                S_DONE:    if (start) w_next = S_ID_REQ;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_ID_REQ: begin
                avm_read = w_go;
                busy     = r_live;
            end
            S_ID_WAIT: busy = r_live;
            S_TS_REQ: begin
                avm_read    = w_go;
                avm_address = 1'b1;
                busy        = r_live;
            end
            S_TS_WAIT: begin
                avm_address = 1'b1;
                busy        = r_live;
            end
            S_CHECK:   busy = r_live;
            default:   ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live  <= 1'b0;
            r_drop  <= 1'b0;
            r_tcnt  <= 16'd0;
            r_retry <= 4'd0;
            r_id    <= 32'd0;
            r_ts    <= 32'd0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_drop <= w_retry;

            if (w_enter_req) begin
                r_tcnt <= 16'd0;
            end else if (w_go & (w_req | w_wait)) begin
                r_tcnt <= r_tcnt + 16'd1;
            end

            if (w_take & w_id_phase)  r_id <= avm_readdata;
            if (w_take & ~w_id_phase) r_ts <= avm_readdata;

            if (w_retry) r_retry <= r_retry + 4'd1;

            if (w_go && r_state == S_CHECK) begin
                r_done <= 1'b1;
                r_pass <= w_pass_cond;
                r_fail <= ~w_pass_cond;
                r_tmo  <= 1'b0;
            end else if (w_tmo & ~w_retry) begin
                r_done <= 1'b1;
                r_pass <= 1'b0;
                r_fail <= 1'b1;
                r_tmo  <= 1'b1;
            end else if (w_go && r_state == S_DONE && start) begin
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
                r_fail  <= 1'b0;
                r_tmo   <= 1'b0;
                r_retry <= 4'd0;
            end
        end
    end

    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign timeout  = r_tmo;
    assign id_value = r_id;
    assign ts_value = r_ts;

endmodule
